// File: rtl/vera_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vera_pkg
//  Description : Shared constants for the layer mixer: register map, video
//                mode encodings, sprite Z levels and counter limits.
//  Revision    : 1.0 - initial release
// ============================================================================
package vera_pkg;

    // Register map
    localparam logic [4:0] REG_CTRL     = 5'h00;
    localparam logic [4:0] REG_HSCALE   = 5'h01;
    localparam logic [4:0] REG_VSCALE   = 5'h02;
    localparam logic [4:0] REG_BORDER   = 5'h03;
    localparam logic [4:0] REG_HSTART_L = 5'h04;
    localparam logic [4:0] REG_HSTOP_L  = 5'h05;
    localparam logic [4:0] REG_VSTART_L = 5'h06;
    localparam logic [4:0] REG_VSTOP_L  = 5'h07;
    localparam logic [4:0] REG_HV_HIGH  = 5'h08;

    // Output modes; bit 1 set means an interlaced (composite) mode
    localparam logic [1:0] MODE_OFF  = 2'd0;
    localparam logic [1:0] MODE_VGA  = 2'd1;
    localparam logic [1:0] MODE_NTSC = 2'd2;
    localparam logic [1:0] MODE_RGB  = 2'd3;

    // Sprite Z levels
    localparam logic [1:0] Z_HIDDEN = 2'd0;
    localparam logic [1:0] Z_BACK   = 2'd1;
    localparam logic [1:0] Z_MID    = 2'd2;
    localparam logic [1:0] Z_FRONT  = 2'd3;

    // Integer limits of the scaled counters
    localparam logic [9:0] H_LIMIT = 10'd640;
    localparam logic [8:0] V_LIMIT = 9'd480;

    typedef enum logic [0:0] {
        RS_IDLE = 1'b0,
        RS_BUSY = 1'b1
    } render_state_t;

endpackage
`default_nettype wire

// File: rtl/layer_priority_mux.sv
`default_nettype none
// ============================================================================
//  Module      : layer_priority_mux
//  Description : Combinational Z-priority selector. Bottom to top:
//                sprite Z1, layer0, sprite Z2, layer1, sprite Z3, layer2.
//                Colour 0 is transparent; absent layers never win.
//  Revision    : 1.0 - initial release
// ============================================================================
module layer_priority_mux import vera_pkg::*; #(
    parameter int NUM_LAYERS = 2
) (
    input  logic [8*NUM_LAYERS-1:0] layer_color,
    input  logic [NUM_LAYERS-1:0]   layer_en,
    input  logic [7:0]              sprite_color,
    input  logic [1:0]              sprite_z,
    input  logic                    sprite_en,
    output logic [7:0]              color
);

    logic [23:0] col3;
    logic [2:0]  en3;
    logic [2:0]  opaque;
    logic        sprite_vis;

    // Pad the layer set to three slots; missing slots are always transparent
    genvar k;
    generate
        for (k = 0; k < 3; k++) begin : g_layer
            if (k < NUM_LAYERS) begin : g_present
                assign col3[8*k +: 8] = layer_color[8*k +: 8];
                assign en3[k]         = layer_en[k];
            end else begin : g_absent
                assign col3[8*k +: 8] = 8'h00;
                assign en3[k]         = 1'b0;
            end
            assign opaque[k] = en3[k] && (col3[8*k +: 8] != 8'h00);
        end
    endgenerate

    assign sprite_vis = sprite_en && (sprite_color != 8'h00);

    // Paint from the bottom up so the last opaque source wins
    always_comb begin
        color = 8'h00;
        if (sprite_vis && sprite_z == Z_BACK)  color = sprite_color;
        if (opaque[0])                         color = col3[7:0];
        if (sprite_vis && sprite_z == Z_MID)   color = sprite_color;
        if (opaque[1])                         color = col3[15:8];
        if (sprite_vis && sprite_z == Z_FRONT) color = sprite_color;
        if (opaque[2])                         color = col3[23:16];
    end

endmodule
`default_nettype wire

// File: rtl/layer_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : layer_mixer
//  Description : Blends NUM_LAYERS layer line buffers and one sprite line
//                buffer into the palette index stream, drives the scaled
//                x/y read indices and tracks per-line render completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module layer_mixer import vera_pkg::*; #(
    parameter int NUM_LAYERS = 2,
    parameter int LB_ADDR_W  = 10,
    parameter int FRAC_BITS  = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4:0]              regs_addr,
    input  logic [7:0]              regs_wrdata,
    input  logic                    regs_write,
    output logic [7:0]              regs_rddata,
    output logic [8:0]              line_idx,
    output logic                    line_render_start,
    input  logic [NUM_LAYERS-1:0]   layer_render_done,
    input  logic                    sprites_render_done,
    input  logic [NUM_LAYERS-1:0]   layer_enabled,
    input  logic                    sprites_enabled,
    output logic [LB_ADDR_W-1:0]    lb_rdidx,
    input  logic [8*NUM_LAYERS-1:0] layer_lb_rddata,
    input  logic [15:0]             sprite_lb_rddata,
    output logic                    sprite_lb_erase_start,
    input  logic                    display_next_frame,
    input  logic                    display_next_line,
    input  logic                    display_next_pixel,
    input  logic                    display_current_field,
    output logic [7:0]              display_data,
    output logic [1:0]              display_mode,
    output logic                    chroma_disable,
    output logic                    underrun
);

    localparam int SX_W = LB_ADDR_W + FRAC_BITS;
    localparam int SY_W = 9 + FRAC_BITS;
    localparam logic [SX_W-1:0] SX_MAX = SX_W'(H_LIMIT) << FRAC_BITS;
    localparam logic [SY_W-1:0] SY_MAX = SY_W'(V_LIMIT) << FRAC_BITS;

    // Register file
    logic [1:0] mode;
    logic       chroma_dis;
    logic [7:0] hscale, vscale, border;
    logic [9:0] hstart, hstop;
    logic [8:0] vstart, vstop;
    logic       field;

    // Counters
    logic [10:0]     x_count, x_next, erase_target;
    logic [11:0]     x_sum;
    logic [9:0]      y_count, y_next;
    logic [10:0]     y_sum;
    logic [SX_W-1:0] scaled_x, sx_sum, sx_next;
    logic [SY_W-1:0] scaled_y, sy_sum, sy_next;
    logic [7:0]      sx_inc;
    logic [8:0]      sy_inc;
    logic            interlaced, h_active, v_active, active_d1;
    logic [9:0]      pix_x;

    // Render tracking
    render_state_t     state, state_next;
    logic [NUM_LAYERS:0] done_mask, mask_next, src_enabled, done_now, mask_now;
    logic              underrun_set, w1c_underrun;

    logic [7:0] mix_color;
    logic       unused_sprite_bits;

    assign interlaced     = mode[1];
    assign display_mode   = mode;
    assign chroma_disable = chroma_dis;
    assign lb_rdidx       = scaled_x[FRAC_BITS +: LB_ADDR_W];
    assign line_idx       = scaled_y[FRAC_BITS +: 9];
    assign unused_sprite_bits = ^sprite_lb_rddata[15:10];

    // Register writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode       <= MODE_OFF;
            chroma_dis <= 1'b0;
            hscale     <= 8'd128;
            vscale     <= 8'd128;
            border     <= 8'h00;
            hstart     <= 10'd0;
            hstop      <= H_LIMIT;
            vstart     <= 9'd0;
            vstop      <= V_LIMIT;
        end else if (regs_write) begin
            case (regs_addr)
                REG_CTRL: begin
                    mode       <= regs_wrdata[1:0];
                    chroma_dis <= regs_wrdata[2];
                end
                REG_HSCALE:   hscale      <= regs_wrdata;
                REG_VSCALE:   vscale      <= regs_wrdata;
                REG_BORDER:   border      <= regs_wrdata;
                REG_HSTART_L: hstart[7:0] <= regs_wrdata;
                REG_HSTOP_L:  hstop[7:0]  <= regs_wrdata;
                REG_VSTART_L: vstart[7:0] <= regs_wrdata;
                REG_VSTOP_L:  vstop[7:0]  <= regs_wrdata;
                REG_HV_HIGH: begin
                    hstart[9:8] <= regs_wrdata[1:0];
                    hstop[9:8]  <= regs_wrdata[3:2];
                    vstart[8]   <= regs_wrdata[4];
                    vstop[8]    <= regs_wrdata[5];
                end
                default: ;
            endcase
        end
    end

    // Combinational register read-back
    always_comb begin
        regs_rddata = 8'h00;
        case (regs_addr)
            REG_CTRL:     regs_rddata = {field, underrun, 3'b000, chroma_dis, mode};
            REG_HSCALE:   regs_rddata = hscale;
            REG_VSCALE:   regs_rddata = vscale;
            REG_BORDER:   regs_rddata = border;
            REG_HSTART_L: regs_rddata = hstart[7:0];
            REG_HSTOP_L:  regs_rddata = hstop[7:0];
            REG_VSTART_L: regs_rddata = vstart[7:0];
            REG_VSTOP_L:  regs_rddata = vstop[7:0];
            REG_HV_HIGH:  regs_rddata = {2'b00, vstop[8], vstart[8], hstop[9:8], hstart[9:8]};
            default:      regs_rddata = 8'h00;
        endcase
    end

    // Next values of the raw and scaled counters, all saturating
    always_comb begin
        pix_x    = x_count[10:1];
        h_active = (pix_x >= hstart) && (pix_x < hstop);
        v_active = (y_count >= {1'b0, vstart}) && (y_count < {1'b0, vstop});

        x_sum  = {1'b0, x_count} + (interlaced ? 12'd1 : 12'd2);
        x_next = x_sum[11] ? 11'h7FF : x_sum[10:0];
        y_sum  = {1'b0, y_count} + (interlaced ? 11'd2 : 11'd1);
        y_next = y_sum[10] ? 10'h3FF : y_sum[9:0];

        sx_inc  = interlaced ? {1'b0, hscale[7:1]} : hscale;
        sx_sum  = scaled_x + SX_W'(sx_inc);
        sx_next = (sx_sum > SX_MAX) ? SX_MAX : sx_sum;
        sy_inc  = interlaced ? {vscale, 1'b0} : {1'b0, vscale};
        sy_sum  = scaled_y + SY_W'(sy_inc);
        sy_next = (sy_sum > SY_MAX) ? SY_MAX : sy_sum;

        erase_target = {10'd639, interlaced};
    end

    // Counter registers; a frame load overrides a coincident line step on y
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_count  <= 11'd0;
            y_count  <= 10'd0;
            scaled_x <= '0;
            scaled_y <= '0;
            sprite_lb_erase_start <= 1'b0;
        end else begin
            sprite_lb_erase_start <= display_next_pixel && !display_next_line &&
                                     (x_next == erase_target) && (x_count != erase_target);
            if (display_next_line) begin
                x_count  <= 11'd0;
                scaled_x <= '0;
            end else if (display_next_pixel) begin
                x_count <= x_next;
                if (h_active) scaled_x <= sx_next;
            end
            if (display_next_frame) begin
                if (interlaced && !display_current_field) begin
                    y_count  <= 10'd1;
                    scaled_y <= SY_W'(vscale);
                end else begin
                    y_count  <= 10'd0;
                    scaled_y <= '0;
                end
            end else if (display_next_line) begin
                y_count <= y_next;
                if (v_active) scaled_y <= sy_next;
            end
        end
    end

    layer_priority_mux #(
        .NUM_LAYERS (NUM_LAYERS)
    ) u_prio (
        .layer_color  (layer_lb_rddata),
        .layer_en     (layer_enabled),
        .sprite_color (sprite_lb_rddata[7:0]),
        .sprite_z     (sprite_lb_rddata[9:8]),
        .sprite_en    (sprites_enabled),
        .color        (mix_color)
    );

    // Output pipeline: window flag delayed to line up with line-buffer data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_d1    <= 1'b0;
            display_data <= 8'h00;
        end else begin
            active_d1    <= h_active && v_active;
            display_data <= active_d1 ? mix_color : border;
        end
    end

    assign src_enabled = {sprites_enabled, layer_enabled};
    assign done_now    = {sprites_render_done, layer_render_done};
    assign mask_now    = done_mask | done_now;

    // Render FSM next-state: disabled sources are pre-marked done on entry
    always_comb begin
        state_next   = state;
        mask_next    = done_mask;
        underrun_set = 1'b0;
        case (state)
            RS_IDLE: begin
                if (display_next_line) begin
                    state_next = RS_BUSY;
                    mask_next  = ~src_enabled;
                end
            end
            RS_BUSY: begin
                mask_next = mask_now;
                if (display_next_line) begin
                    underrun_set = ~&mask_now;
                    mask_next    = ~src_enabled;
                end else if (&mask_now) begin
                    state_next = RS_IDLE;
                end
            end
            default: state_next = RS_IDLE;
        endcase
    end

    // Render FSM state, start pulse and field sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= RS_IDLE;
            done_mask         <= '0;
            line_render_start <= 1'b0;
            field             <= 1'b0;
        end else begin
            state             <= state_next;
            done_mask         <= mask_next;
            line_render_start <= display_next_line;
            field             <= display_current_field;
        end
    end

    assign w1c_underrun = regs_write && (regs_addr == REG_CTRL) && regs_wrdata[6];

    // Sticky underrun flag; a new underrun beats a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               underrun <= 1'b0;
        else if (underrun_set) underrun <= 1'b1;
        else if (w1c_underrun) underrun <= 1'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_layer_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_layer_mixer
//  Description : Directed self-checking bench for layer_mixer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_mixer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  regs_addr = 5'd0;
    logic [7:0]  regs_wrdata = 8'd0;
    logic        regs_write = 1'b0;
    logic [7:0]  regs_rddata;
    logic [8:0]  line_idx;
    logic        line_render_start;
    logic [1:0]  layer_render_done = 2'b00;
    logic        sprites_render_done = 1'b0;
    logic [1:0]  layer_enabled = 2'b11;
    logic        sprites_enabled = 1'b0;
    logic [9:0]  lb_rdidx;
    logic [15:0] layer_lb_rddata;
    logic [15:0] sprite_lb_rddata = 16'h0000;
    logic        sprite_lb_erase_start;
    logic        display_next_frame = 1'b0;
    logic        display_next_line = 1'b0;
    logic        display_next_pixel = 1'b0;
    logic        display_current_field = 1'b0;
    logic [7:0]  display_data;
    logic [1:0]  display_mode;
    logic        chroma_disable;
    logic        underrun;

    logic [15:0] lb_direct = 16'h0000;
    logic [15:0] lb_model = 16'h0000;
    logic        lb_model_on = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Line-buffer model with one clock of read latency
    always @(posedge clk) lb_model <= {8'h00, 8'h10 + lb_rdidx[7:0]};
    assign layer_lb_rddata = lb_model_on ? lb_model : lb_direct;

    layer_mixer #(.NUM_LAYERS(2), .LB_ADDR_W(10), .FRAC_BITS(7)) dut (
        .clk(clk), .rst(rst),
        .regs_addr(regs_addr), .regs_wrdata(regs_wrdata), .regs_write(regs_write),
        .regs_rddata(regs_rddata),
        .line_idx(line_idx), .line_render_start(line_render_start),
        .layer_render_done(layer_render_done), .sprites_render_done(sprites_render_done),
        .layer_enabled(layer_enabled), .sprites_enabled(sprites_enabled),
        .lb_rdidx(lb_rdidx), .layer_lb_rddata(layer_lb_rddata),
        .sprite_lb_rddata(sprite_lb_rddata), .sprite_lb_erase_start(sprite_lb_erase_start),
        .display_next_frame(display_next_frame), .display_next_line(display_next_line),
        .display_next_pixel(display_next_pixel), .display_current_field(display_current_field),
        .display_data(display_data), .display_mode(display_mode),
        .chroma_disable(chroma_disable), .underrun(underrun)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reg_write(input logic [4:0] a, input logic [7:0] d);
        regs_addr = a; regs_wrdata = d; regs_write = 1'b1;
        tick();
        regs_write = 1'b0;
    endtask

    task automatic reg_read(input logic [4:0] a, output logic [7:0] d);
        regs_addr = a;
        #1;
        d = regs_rddata;
    endtask

    task automatic pulse_line();
        display_next_line = 1'b1;
        tick();
        display_next_line = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] exp_regs [0:8];
        logic [7:0] rd;
        exp_regs = '{8'h00, 8'h80, 8'h80, 8'h00, 8'h00, 8'h80, 8'h00, 8'hE0, 8'h28};
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick();
        checks++; if (display_data !== 8'h00) begin errors++; $display("FAIL reset_display_data: got %h expected 00", display_data); end
        checks++; if (line_render_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", line_render_start); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
        checks++; if (lb_rdidx !== 10'd0) begin errors++; $display("FAIL reset_lb_rdidx: got %0d expected 0", lb_rdidx); end
        checks++; if (line_idx !== 9'd0) begin errors++; $display("FAIL reset_line_idx: got %0d expected 0", line_idx); end
        for (int a = 0; a < 9; a++) begin
            reg_read(5'(a), rd);
            checks++; if (rd !== exp_regs[a]) begin errors++; $display("FAIL reset_reg_%0d: got %h expected %h", a, rd, exp_regs[a]); end
        end
        reg_read(5'h1F, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL unmapped_reg: got %h expected 00", rd); end
        reg_write(5'h00, 8'h05);
        checks++; if (display_mode !== 2'd1 || chroma_disable !== 1'b1) begin errors++; $display("FAIL ctrl_outputs: got mode %0d chroma %b expected 1 1", display_mode, chroma_disable); end
        reg_write(5'h00, 8'h01);
    endtask

    task automatic test_composite();
        lb_model_on = 1'b0;
        layer_enabled = 2'b11;
        sprites_enabled = 1'b1;
        lb_direct = {8'h22, 8'h11}; sprite_lb_rddata = {6'd0, 2'd2, 8'h33};
        tick(3);
        checks++; if (display_data !== 8'h22) begin errors++; $display("FAIL comp_layer1_top: got %h expected 22", display_data); end
        lb_direct = {8'h00, 8'h11};
        tick(3);
        checks++; if (display_data !== 8'h33) begin errors++; $display("FAIL comp_sprite_z2: got %h expected 33", display_data); end
        sprite_lb_rddata = {6'd0, 2'd0, 8'h33};
        tick(3);
        checks++; if (display_data !== 8'h11) begin errors++; $display("FAIL comp_sprite_z0: got %h expected 11", display_data); end
        lb_direct = {8'h22, 8'h11}; sprite_lb_rddata = {6'd0, 2'd3, 8'h33};
        tick(3);
        checks++; if (display_data !== 8'h33) begin errors++; $display("FAIL comp_sprite_z3: got %h expected 33", display_data); end
        sprite_lb_rddata = {6'd0, 2'd1, 8'h33}; lb_direct = {8'h00, 8'h00};
        tick(3);
        checks++; if (display_data !== 8'h33) begin errors++; $display("FAIL comp_sprite_z1_alone: got %h expected 33", display_data); end
        lb_direct = {8'h00, 8'h11};
        tick(3);
        checks++; if (display_data !== 8'h11) begin errors++; $display("FAIL comp_layer0_over_z1: got %h expected 11", display_data); end
        lb_direct = {8'h22, 8'h11}; layer_enabled = 2'b01; sprite_lb_rddata = 16'h0000;
        tick(3);
        checks++; if (display_data !== 8'h11) begin errors++; $display("FAIL comp_layer1_disabled: got %h expected 11", display_data); end
        lb_direct = 16'h0000; layer_enabled = 2'b11;
        tick(3);
        checks++; if (display_data !== 8'h00) begin errors++; $display("FAIL comp_all_transparent: got %h expected 00", display_data); end
        sprites_enabled = 1'b0;
    endtask

    task automatic test_hscale();
        reg_write(5'h01, 8'd64);
        lb_model_on = 1'b1;
        pulse_line();
        tick(2);
        display_next_pixel = 1'b1;
        for (int k = 0; k < 10; k++) begin
            checks++; if (lb_rdidx !== 10'(k / 2)) begin errors++; $display("FAIL hscale_rdidx_%0d: got %0d expected %0d", k, lb_rdidx, k / 2); end
            if (k >= 2) begin
                checks++; if (display_data !== 8'(8'h10 + (k - 2) / 2)) begin errors++; $display("FAIL hscale_data_%0d: got %h expected %h", k, display_data, 8'(8'h10 + (k - 2) / 2)); end
            end
            tick();
        end
        display_next_pixel = 1'b0;
        lb_model_on = 1'b0;
        reg_write(5'h01, 8'd128);
    endtask

    task automatic test_underrun();
        logic [7:0] rd;
        sprites_enabled = 1'b1; layer_enabled = 2'b11;
        layer_render_done = 2'b11; sprites_render_done = 1'b1;
        tick();
        layer_render_done = 2'b00; sprites_render_done = 1'b0;
        reg_write(5'h00, 8'h41);
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_cleared_initial: got %b expected 0", underrun); end
        display_next_line = 1'b1;
        tick();
        display_next_line = 1'b0;
        checks++; if (line_render_start !== 1'b1) begin errors++; $display("FAIL start_pulse_high: got %b expected 1", line_render_start); end
        tick();
        checks++; if (line_render_start !== 1'b0) begin errors++; $display("FAIL start_pulse_low: got %b expected 0", line_render_start); end
        layer_render_done = 2'b01; tick(); layer_render_done = 2'b00; tick();
        pulse_line();
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set: got %b expected 1", underrun); end
        reg_read(5'h00, rd);
        checks++; if (rd !== 8'h41) begin errors++; $display("FAIL underrun_ctrl_bit6: got %h expected 41", rd); end
        reg_write(5'h00, 8'h41);
        reg_read(5'h00, rd);
        checks++; if (underrun !== 1'b0 || rd !== 8'h01) begin errors++; $display("FAIL underrun_w1c: got flag %b ctrl %h expected 0 01", underrun, rd); end
        // underrun event coinciding with the clear: the set must win
        regs_addr = 5'h00; regs_wrdata = 8'h41; regs_write = 1'b1; display_next_line = 1'b1;
        tick();
        regs_write = 1'b0; display_next_line = 1'b0;
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set_wins: got %b expected 1", underrun); end
        layer_render_done = 2'b11; sprites_render_done = 1'b1; tick();
        layer_render_done = 2'b00; sprites_render_done = 1'b0; tick();
        reg_write(5'h00, 8'h41);
        // sprites disabled count as done at entry
        sprites_enabled = 1'b0;
        pulse_line();
        layer_render_done = 2'b11; tick(); layer_render_done = 2'b00; tick();
        pulse_line();
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL no_underrun_disabled_sprite: got %b expected 0", underrun); end
    endtask

    task automatic test_interlace();
        logic [7:0] rd;
        reg_write(5'h00, 8'h02);
        checks++; if (display_mode !== 2'd2) begin errors++; $display("FAIL mode2_output: got %0d expected 2", display_mode); end
        display_current_field = 1'b0;
        display_next_frame = 1'b1; tick(); display_next_frame = 1'b0;
        checks++; if (line_idx !== 9'd1) begin errors++; $display("FAIL frame_load_field0: got %0d expected 1", line_idx); end
        pulse_line();
        checks++; if (line_idx !== 9'd3) begin errors++; $display("FAIL interlace_line1: got %0d expected 3", line_idx); end
        pulse_line();
        checks++; if (line_idx !== 9'd5) begin errors++; $display("FAIL interlace_line2: got %0d expected 5", line_idx); end
        display_next_frame = 1'b1; display_next_line = 1'b1;
        tick();
        display_next_frame = 1'b0; display_next_line = 1'b0;
        checks++; if (line_idx !== 9'd1 || line_render_start !== 1'b1) begin errors++; $display("FAIL frame_line_same_cycle: got idx %0d start %b expected 1 1", line_idx, line_render_start); end
        for (int i = 0; i < 250; i++) pulse_line();
        checks++; if (line_idx !== 9'd480) begin errors++; $display("FAIL scaled_y_saturate: got %0d expected 480", line_idx); end
        pulse_line();
        checks++; if (line_idx !== 9'd480) begin errors++; $display("FAIL scaled_y_hold: got %0d expected 480", line_idx); end
        display_current_field = 1'b1;
        display_next_frame = 1'b1; tick(); display_next_frame = 1'b0;
        checks++; if (line_idx !== 9'd0) begin errors++; $display("FAIL frame_load_field1: got %0d expected 0", line_idx); end
        reg_read(5'h00, rd);
        checks++; if ((rd & 8'h87) !== 8'h82) begin errors++; $display("FAIL ctrl_field_bit: got %h expected 82 under mask 87", rd & 8'h87); end
        display_current_field = 1'b0;
    endtask

    task automatic test_window();
        logic [7:0] rd;
        reg_write(5'h00, 8'h41);
        reg_write(5'h03, 8'h5A);
        reg_write(5'h04, 8'h10);
        reg_write(5'h05, 8'h70);
        reg_write(5'h06, 8'h08);
        reg_write(5'h07, 8'hD8);
        reg_write(5'h08, 8'h28);
        reg_read(5'h08, rd);
        checks++; if (rd !== 8'h28) begin errors++; $display("FAIL window_high_bits: got %h expected 28", rd); end
        lb_model_on = 1'b0; lb_direct = {8'h00, 8'h11};
        sprites_enabled = 1'b0; layer_enabled = 2'b11;
        display_next_frame = 1'b1; display_next_line = 1'b1;
        tick();
        display_next_frame = 1'b0; display_next_line = 1'b0;
        tick(3);
        checks++; if (display_data !== 8'h5A) begin errors++; $display("FAIL border_top: got %h expected 5A", display_data); end
        for (int i = 0; i < 8; i++) pulse_line();
        tick(3);
        checks++; if (display_data !== 8'h5A) begin errors++; $display("FAIL border_left_x0: got %h expected 5A", display_data); end
        display_next_pixel = 1'b1; tick(15); display_next_pixel = 1'b0;
        tick(3);
        checks++; if (display_data !== 8'h5A) begin errors++; $display("FAIL border_left_x15: got %h expected 5A", display_data); end
        display_next_pixel = 1'b1; tick(); display_next_pixel = 1'b0;
        checks++; if (display_data !== 8'h5A) begin errors++; $display("FAIL window_lat_0: got %h expected 5A", display_data); end
        tick();
        checks++; if (display_data !== 8'h5A) begin errors++; $display("FAIL window_lat_1: got %h expected 5A", display_data); end
        tick();
        checks++; if (display_data !== 8'h11) begin errors++; $display("FAIL window_lat_2: got %h expected 11", display_data); end
    endtask

    initial begin
        test_reset();
        test_composite();
        test_hscale();
        test_underrun();
        test_interlace();
        test_window();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
